// File: rtl/dl_skid_buf.sv
// dl_skid_buf: two-entry valid/ready pipeline register with a skid slot.
// The main register drives out_data. The skid register absorbs one word when
// downstream stalls. in_ready and out_valid decode only from registered state,
// so no combinational path runs from out_ready to in_ready.
// Optional build macro DL_SKID_BUF_STALL_CNT_EN adds a saturating stall counter
// on port stall_cnt.

module dl_skid_buf #(
  parameter int unsigned NUM_BITS = 32,
  parameter int unsigned CNT_BITS = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [NUM_BITS-1:0] in_data,
  output logic                out_valid,
  input  logic                out_ready,
`ifdef DL_SKID_BUF_STALL_CNT_EN
  output logic [NUM_BITS-1:0] out_data,
  output logic [CNT_BITS-1:0] stall_cnt
`else
  output logic [NUM_BITS-1:0] out_data
`endif
);

  // Reject degenerate widths at elaboration.
  if (NUM_BITS < 1 || CNT_BITS < 1) begin : g_param_check
    $error("dl_skid_buf: NUM_BITS and CNT_BITS must be at least 1");
  end

  typedef enum logic [1:0] {
    StEmpty = 2'b00,
    StBusy  = 2'b01,
    StFull  = 2'b10
  } state_e;

  state_e              state_q, state_d;
  logic [NUM_BITS-1:0] main_q, main_d;
  logic [NUM_BITS-1:0] skid_q, skid_d;
  logic                in_fire, out_fire;

  // Handshake decode from registered state only.
  always_comb begin
    in_ready  = (state_q != StFull);
    out_valid = (state_q != StEmpty);
    out_data  = main_q;
    in_fire   = in_valid & in_ready;
    out_fire  = out_valid & out_ready;
  end

  // Next-state and datapath steering.
  always_comb begin
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;
    case (state_q)
      StEmpty: begin
        if (in_fire) begin
          main_d  = in_data;
          state_d = StBusy;
        end
      end
      StBusy: begin
        if (in_fire && out_fire) begin
          main_d = in_data;
        end else if (in_fire) begin
          // Downstream stalled: park the new word behind the held one.
          skid_d  = in_data;
          state_d = StFull;
        end else if (out_fire) begin
          // main_q keeps its stale value; out_valid masks it.
          state_d = StEmpty;
        end
      end
      StFull: begin
        if (out_fire) begin
          main_d  = skid_q;
          state_d = StBusy;
        end
      end
      default: state_d = StEmpty;
    endcase
  end

  // State and data registers; synchronous reset discards held words.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StEmpty;
      main_q  <= '0;
      skid_q  <= '0;
    end else begin
      state_q <= state_d;
      main_q  <= main_d;
      skid_q  <= skid_d;
    end
  end

`ifdef DL_SKID_BUF_STALL_CNT_EN
  logic [CNT_BITS-1:0] stall_cnt_q, stall_cnt_d;

  // Count cycles where a word is offered but refused; stick at all-ones.
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (out_valid && !out_ready && (stall_cnt_q != {CNT_BITS{1'b1}})) begin
      stall_cnt_d = stall_cnt_q + CNT_BITS'(1);
    end
  end

  // Stall counter register.
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign stall_cnt = stall_cnt_q;
`endif

endmodule

// File: tb/tb_dl_skid_buf.sv
// Self-checking bench for dl_skid_buf: directed vector table, a saturation
// sequence, then a random soak scored against a queue-based FIFO model.

module tb_dl_skid_buf;

  localparam int unsigned NB = 32;
  localparam int unsigned CB = 4;
  localparam int unsigned SatMax = (1 << CB) - 1;

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid;
  logic          in_ready;
  logic [NB-1:0] in_data;
  logic          out_valid;
  logic          out_ready;
  logic [NB-1:0] out_data;
`ifdef DL_SKID_BUF_STALL_CNT_EN
  logic [CB-1:0] stall_cnt;
`endif

  always #5 clk = ~clk;

  dl_skid_buf #(
    .NUM_BITS(NB),
    .CNT_BITS(CB)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_data  (in_data),
    .out_valid(out_valid),
    .out_ready(out_ready),
`ifdef DL_SKID_BUF_STALL_CNT_EN
    .out_data (out_data),
    .stall_cnt(stall_cnt)
`else
    .out_data (out_data)
`endif
  );

  typedef struct packed {
    logic        rst;
    logic        v;
    logic [31:0] d;
    logic        r;
    logic        ir;
    logic        ov;
    logic [31:0] od;
    logic        chkd;
    logic [7:0]  sc;
  } vec_t;

  vec_t tbl[$];
  int   n_vec = 0;
  int   n_err = 0;

  function automatic vec_t mk(logic rs, logic v, logic [31:0] d, logic r, logic ir, logic ov,
                              logic [31:0] od, logic chkd, int sc);
    vec_t t;
    t.rst = rs; t.v = v; t.d = d; t.r = r;
    t.ir = ir; t.ov = ov; t.od = od; t.chkd = chkd; t.sc = 8'(sc);
    return t;
  endfunction

  // Drive inputs, then clock once; outputs are sampled 1 time unit after the edge.
  task automatic step(input logic rs, input logic v, input logic [31:0] d, input logic r);
    rst = rs; in_valid = v; in_data = d; out_ready = r;
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string nm, input logic ir, input logic ov, input logic [31:0] od,
                       input logic chkd, input int sc);
    n_vec++;
    if (in_ready !== ir) begin
      n_err++;
      $display("FAIL %s in_ready got %b want %b", nm, in_ready, ir);
    end
    if (out_valid !== ov) begin
      n_err++;
      $display("FAIL %s out_valid got %b want %b", nm, out_valid, ov);
    end
    if (chkd && out_data !== od) begin
      n_err++;
      $display("FAIL %s out_data got %h want %h", nm, out_data, od);
    end
`ifdef DL_SKID_BUF_STALL_CNT_EN
    if (stall_cnt !== CB'(sc)) begin
      n_err++;
      $display("FAIL %s stall_cnt got %0d want %0d", nm, stall_cnt, sc);
    end
`endif
  endtask

  initial begin
    logic [31:0] q[$];
    int          sc_m;
    logic        hold_v;
    logic [31:0] hold_d;
    logic        rs, v, r, fin, fout, stl;
    logic [31:0] d;
    vec_t        t;

    rst = 1'b1; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;

    // rst, v, d, r | in_ready, out_valid, out_data, check data, stall_cnt
    // Reset with a word offered.
    tbl.push_back(mk(1, 1, 32'hDEADBEEF, 0, 1, 0, 32'h0, 1, 0));
    tbl.push_back(mk(1, 1, 32'hDEADBEEF, 0, 1, 0, 32'h0, 1, 0));
    // Streaming.
    tbl.push_back(mk(0, 1, 32'h1, 1, 1, 1, 32'h1, 1, 0));
    tbl.push_back(mk(0, 1, 32'h2, 1, 1, 1, 32'h2, 1, 0));
    tbl.push_back(mk(0, 1, 32'h3, 1, 1, 1, 32'h3, 1, 0));
    tbl.push_back(mk(0, 1, 32'h4, 1, 1, 1, 32'h4, 1, 0));
    tbl.push_back(mk(0, 0, 32'h0, 1, 1, 0, 32'h0, 0, 0));
    // Skid absorb then drain.
    tbl.push_back(mk(0, 1, 32'hA, 0, 1, 1, 32'hA, 1, 0));
    tbl.push_back(mk(0, 1, 32'hB, 0, 0, 1, 32'hA, 1, 1));
    tbl.push_back(mk(0, 0, 32'h0, 1, 1, 1, 32'hB, 1, 1));
    tbl.push_back(mk(0, 0, 32'h0, 1, 1, 0, 32'h0, 0, 1));
    // Refill, then hold under backpressure with 0xC offered.
    tbl.push_back(mk(0, 1, 32'hA, 0, 1, 1, 32'hA, 1, 1));
    tbl.push_back(mk(0, 1, 32'hB, 0, 0, 1, 32'hA, 1, 2));
    for (int i = 0; i < 5; i++) tbl.push_back(mk(0, 1, 32'hC, 0, 0, 1, 32'hA, 1, 3 + i));
    // Reset while full; old words vanish, 0x5 follows in one cycle.
    tbl.push_back(mk(1, 1, 32'hC, 0, 1, 0, 32'h0, 1, 0));
    tbl.push_back(mk(0, 1, 32'h5, 0, 1, 1, 32'h5, 1, 0));
    tbl.push_back(mk(0, 0, 32'h0, 1, 1, 0, 32'h0, 0, 0));
    // out_ready toggling while empty has no effect.
    tbl.push_back(mk(0, 0, 32'h0, 0, 1, 0, 32'h0, 0, 0));
    tbl.push_back(mk(0, 0, 32'h0, 1, 1, 0, 32'h0, 0, 0));

    foreach (tbl[i]) begin
      t = tbl[i];
      step(t.rst, t.v, t.d, t.r);
      check($sformatf("vec%0d", i), t.ir, t.ov, t.od, t.chkd, int'(t.sc));
    end

    // Saturation: hold one word stalled past the counter ceiling.
    step(0, 1, 32'h77, 0);
    check("sat_load", 1'b1, 1'b1, 32'h77, 1'b1, 0);
    for (int i = 1; i <= 20; i++) begin
      step(0, 0, 32'h0, 0);
      check($sformatf("sat%0d", i), 1'b1, 1'b1, 32'h77, 1'b1, (i > 15) ? 15 : i);
    end
    step(0, 0, 32'h0, 1);
    check("sat_drain", 1'b1, 1'b0, 32'h0, 1'b0, 15);

    // Random soak against a FIFO model of capacity two.
    q.delete();
    sc_m   = 0;
    hold_v = 1'b0;
    hold_d = '0;
    step(1, 0, 32'h0, 0);
    check("soak_rst", 1'b1, 1'b0, 32'h0, 1'b1, 0);
    for (int i = 0; i < 500; i++) begin
      rs = ($urandom_range(0, 59) == 0);
      if (hold_v) begin
        v = 1'b1;
        d = hold_d;
      end else begin
        v = ($urandom_range(0, 9) < 7);
        d = $urandom;
      end
      r   = ($urandom_range(0, 9) < 5);
      fin  = v && (q.size() < 2);
      fout = (q.size() > 0) && r;
      stl  = (q.size() > 0) && !r;
      step(rs, v, d, r);
      if (rs) begin
        q.delete();
        sc_m = 0;
      end else begin
        if (stl && sc_m < int'(SatMax)) sc_m++;
        if (fout) void'(q.pop_front());
        if (fin) q.push_back(d);
      end
      hold_v = v && !fin && !rs;
      hold_d = d;
      check($sformatf("soak%0d", i), q.size() < 2, q.size() > 0,
            (q.size() > 0) ? q[0] : 32'h0, q.size() > 0, sc_m);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
